sdu_seq_ctrl: RTL and testbench
===============================

# sdu_seq_ctrl

Sequence controller for the SDUltrasound transmit path. Sits directly upstream of the TX replay stage and generates its `sdu_tx_en` gate and `sdu_seq_done_strobe`. Each run is a programmed number of transmit sequences, each followed by a listen interval, at a fixed pulse repetition period. Settings come from the host settings bus; start and abort are single-cycle host strobes.

## Interface
- `CNT_W`, default 16: width of the sequence-length and period counters. Matches the 16-bit TX sample RAM address.
- `BURST_W`, default 16: width of the burst count and the completed-sequence counter.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `set_seq_len`  in  CNT_W  samples per transmit sequence. Latched on accepted `start`.
- `set_period`  in  CNT_W  cycles per repetition interval (TX + listen). Latched on accepted `start`.
- `set_bursts`  in  BURST_W  number of sequences per run. 0 = continuous.
- `start`  in  1  one-cycle strobe that begins a run.
- `abort`  in  1  one-cycle strobe that ends a run immediately.
- `sdu_tx_en`  out  1  gate to the TX replay stage.
- `sdu_seq_done_strobe`  out  1  one-cycle pulse at the end of each transmit sequence.
- `busy`  out  1  high while a run is in progress.
- `start_err`  out  1  one-cycle pulse when `start` is rejected because the settings are invalid.
- `seq_count`  out  BURST_W  number of sequences completed in the current or last run.

## Operation
- **States:** IDLE, TX, LISTEN. A `phase` counter (CNT_W bits) runs 0..period-1. A remaining-burst counter tracks how many sequences are left.
- **Reset** (asynchronous, while `reset`=0): state IDLE, all counters 0, every output 0.
- **IDLE:**
  - `start` is accepted only if `set_seq_len`≠0 and `set_period` ≥ `set_seq_len`+1.
  - On acceptance: latch the settings, clear `seq_count`, set phase=0, go to TX.
  - Otherwise pulse `start_err` and stay in IDLE.
  - The "+1" rule guarantees `sdu_tx_en` drops for at least one cycle between sequences, so the TX replay stage rewinds its read index to 0.
- **TX:**
  - `sdu_tx_en`=1 and phase increments each cycle.
  - When phase = len-1, go to LISTEN on the next cycle.
- **LISTEN:**
  - `sdu_tx_en`=0.
  - On the first LISTEN cycle, `sdu_seq_done_strobe`=1 for exactly one cycle and `seq_count` increments (wraps modulo 2^BURST_W).
  - When phase = period-1, one of:
    - bursts remaining (or continuous mode): phase=0, go to TX.
    - no bursts remaining: go to IDLE.
- **busy:** 1 in TX and LISTEN, 0 in IDLE.
- **abort:**
  - From any state, go to IDLE on the next cycle with `sdu_tx_en`=0.
  - No done strobe is issued for a truncated sequence.
  - `seq_count` is held, not cleared.
- **Simultaneous events:**
  - `start` while busy is ignored and does not raise `start_err`.
  - `start` together with `abort` in IDLE: abort wins and `start` is ignored.
  - Settings inputs may change at any time; only the values latched at start are used.

## Timing
- All outputs are registered.
- `start` sampled at edge T gives `busy`=1 and `sdu_tx_en`=1 from cycle T+1.
- `sdu_tx_en` stays high for exactly `seq_len` cycles.
- `sdu_seq_done_strobe` is asserted on cycle T+1+len, which is the first cycle with `sdu_tx_en`=0.
- The next sequence's `sdu_tx_en` rises at T+1+period, giving a period of exactly `period` cycles.
- The final LISTEN cycle of the last burst is T+bursts·period. `busy` falls at T+1+bursts·period.
- A new `start` is accepted on the cycle `busy` reads 0, which gives back-to-back runs with no extra gap.
- `start_err` is asserted on cycle T+1 for one cycle.
- `abort` at edge A gives `sdu_tx_en`=0 and `busy`=0 from A+1.
- Edge case: len=1, period=2 alternates 1,0,1,0 on `sdu_tx_en` and pulses the done strobe on every 0 cycle.

## Test plan
- Reset, then len=4, period=10, bursts=3, `start` at T -> `sdu_tx_en` high at T+1..T+4, T+11..T+14, T+21..T+24; done strobes at T+5, T+15, T+25; `busy` falls at T+31; `seq_count`=3.
- len=5, period=5 (invalid) -> `start_err` pulse at T+1; `busy`, `sdu_tx_en` and the done strobe stay 0. Then len=0, period=8 -> same rejection.
- bursts=0 (continuous), len=2, period=3 -> pattern 1,1,0 repeats through more than 20 periods; `abort` mid-TX -> `sdu_tx_en` 0 on the next cycle, no done strobe, `seq_count` equals the number of completed sequences.
- `start` while busy, `start`+`abort` in the same IDLE cycle, and settings changed mid-run -> each is ignored; the timing matches the latched settings.
- Assert `reset` low asynchronously mid-TX (between clock edges) -> all outputs 0 immediately; after release, `start` with len=1, period=2, bursts=2 -> `sdu_tx_en` 1,0,1,0 and `seq_count`=2.

Source files
------------

// File: rtl/sdu_seq_ctrl.sv
// Transmit sequence controller for the SDUltrasound TX path: gates the TX replay
// stage for seq_len cycles out of every period, for a programmed number of bursts.
module sdu_seq_ctrl #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   set_seq_len,
  input  logic [CNT_W-1:0]   set_period,
  input  logic [BURST_W-1:0] set_bursts,
  input  logic               start,
  input  logic               abort,
  output logic               sdu_tx_en,
  output logic               sdu_seq_done_strobe,
  output logic               busy,
  output logic               start_err,
  output logic [BURST_W-1:0] seq_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TX     = 2'd1,
    LISTEN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               settings_ok;

  // period > len keeps at least one idle cycle between sequences so the
  // replay stage sees tx_en drop and rewinds its read index.
  assign settings_ok = (set_seq_len != '0) && (set_period > set_seq_len);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    len_d    = len_q;
    period_d = period_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    cont_d   = cont_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (settings_ok) begin
            len_d    = set_seq_len;
            period_d = set_period;
            rem_d    = set_bursts;
            cont_d   = (set_bursts == '0);
            cnt_d    = '0;
            phase_d  = '0;
            state_d  = TX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      TX: begin
        phase_d = phase_q + CNT_ONE;
        if (phase_q == len_q - CNT_ONE) begin
          state_d = LISTEN;
          done_d  = 1'b1;
          cnt_d   = cnt_q + BURST_ONE;
          if (!cont_q) rem_d = rem_q - BURST_ONE;
        end
      end
      LISTEN: begin
        if (phase_q == period_q - CNT_ONE) begin
          if (cont_q || (rem_q != '0)) begin
            phase_d = '0;
            state_d = TX;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort truncates the current sequence without crediting it.
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      len_q    <= '0;
      period_q <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      len_q    <= len_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sdu_tx_en           = (state_q == TX);
  assign busy                = (state_q != IDLE);
  assign sdu_seq_done_strobe = done_q;
  assign start_err           = err_q;
  assign seq_count           = cnt_q;

endmodule

// File: tb/tb_sdu_seq_ctrl.sv
// Self-checking bench for sdu_seq_ctrl against a cycle-index arithmetic model.
module tb_sdu_seq_ctrl;
  logic        clk;
  logic        reset;
  logic [15:0] set_seq_len;
  logic [15:0] set_period;
  logic [15:0] set_bursts;
  logic        start;
  logic        abort;
  logic        sdu_tx_en;
  logic        sdu_seq_done_strobe;
  logic        busy;
  logic        start_err;
  logic [15:0] seq_count;

  int total = 0;
  int bad = 0;
  int last_cnt = 0;
  logic [19:0] ov, ev;

  sdu_seq_ctrl #(.CNT_W(16), .BURST_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .set_seq_len(set_seq_len),
    .set_period(set_period),
    .set_bursts(set_bursts),
    .start(start),
    .abort(abort),
    .sdu_tx_en(sdu_tx_en),
    .sdu_seq_done_strobe(sdu_seq_done_strobe),
    .busy(busy),
    .start_err(start_err),
    .seq_count(seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {tx_en, done, busy, start_err, seq_count} for cycle k of a run whose
  // start was sampled at edge T (cycle k lies between edges T+k-1 and T+k).
  function automatic logic [19:0] model(input int k, input int l, input int p,
                                         input int b, input int ak);
    int  runlen, lim, off, kk, c;
    bit  act;
    runlen = (b == 0) ? 32'h7fffffff : b * p;
    lim    = runlen;
    if (ak > 0 && ak < lim) lim = ak;
    act = (k >= 1) && (k <= lim);
    off = (k - 1) % p;
    kk  = (k < lim) ? k : lim;
    c   = (kk - 1 >= l) ? (kk - 1 - l) / p + 1 : 0;
    return {act && (off < l), act && (off == l), act, 1'b0, 16'(c)};
  endfunction

  function automatic logic [19:0] observe();
    return {sdu_tx_en, sdu_seq_done_strobe, busy, start_err, seq_count};
  endfunction

  task automatic begin_run(input int l, input int p, input int b);
    set_seq_len = 16'(l);
    set_period  = 16'(p);
    set_bursts  = 16'(b);
    start       = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    set_seq_len = 16'd0; set_period = 16'd0; set_bursts = 16'd0;
    #3;
    total++;
    if (observe() !== 20'h0) begin
      bad++; $display("FAIL reset_initial got=%h exp=%h", observe(), 20'h0);
    end
    begin_run(2, 4, 1);
    repeat (2) @(negedge clk);
    total++;
    if (observe() !== 20'h0) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", observe(), 20'h0);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (observe() !== 20'h0) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", observe(), 20'h0);
    end
  endtask

  task automatic test_basic();
    begin_run(4, 10, 3);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk); start = 1'b0;
      ev = model(k, 4, 10, 3, 0); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL basic k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    last_cnt = 3;
  endtask

  task automatic test_invalid();
    int ls[2] = '{5, 0};
    int ps[2] = '{5, 8};
    for (int t = 0; t < 2; t++) begin
      begin_run(ls[t], ps[t], 1);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk); start = 1'b0;
        ev = {3'b000, (k == 1), 16'(last_cnt)}; ov = observe();
        total++;
        if (ov !== ev) begin
          bad++; $display("FAIL invalid t=%0d k=%0d got=%h exp=%h", t, k, ov, ev);
        end
      end
    end
  endtask

  task automatic test_start_abort_idle();
    begin_run(2, 5, 1);
    abort = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); start = 1'b0; abort = 1'b0;
      ev = {4'b0000, 16'(last_cnt)}; ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL start_abort_idle k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
  endtask

  task automatic test_ignored_mid_run();
    begin_run(3, 7, 2);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start       = (k <= 14) && ($urandom_range(0, 2) == 0);
      set_seq_len = 16'($urandom_range(0, 20));
      set_period  = 16'($urandom_range(0, 20));
      set_bursts  = 16'($urandom);
      ev = model(k, 3, 7, 2, 0); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL ignored_mid_run k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    start = 1'b0;
    last_cnt = 2;
  endtask

  task automatic test_continuous_abort();
    begin_run(2, 3, 0);
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk); start = 1'b0; abort = (k == 65);
      ev = model(k, 2, 3, 0, 65); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL continuous_abort k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    abort = 1'b0;
    last_cnt = 21;
  endtask

  task automatic test_back_to_back();
    begin_run(2, 4, 2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); start = 1'b0;
      ev = model(k, 2, 4, 2, 0); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL back_to_back_a k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    begin_run(1, 3, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); start = 1'b0;
      ev = model(k, 1, 3, 1, 0); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL back_to_back_b k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    last_cnt = 1;
  endtask

  task automatic test_async_reset();
    begin_run(3, 6, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (observe() !== 20'h0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", observe(), 20'h0);
    end
    @(negedge clk); reset = 1'b1;
    begin_run(1, 2, 2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = 1'b0;
      ev = model(k, 1, 2, 2, 0); ov = observe();
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL after_reset k=%0d got=%h exp=%h", k, ov, ev);
      end
    end
    total++;
    if (seq_count !== 16'd2) begin
      bad++; $display("FAIL after_reset_count got=%0d exp=2", seq_count);
    end
    last_cnt = 2;
  endtask

  task automatic test_random();
    int l, p, b, ak, n;
    for (int r = 0; r < 10; r++) begin
      l = $urandom_range(1, 6);
      p = $urandom_range(l + 1, l + 6);
      b = $urandom_range(0, 3);
      if (b == 0) ak = $urandom_range(2, 30);
      else ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, b * p) : 0;
      n = (ak > 0) ? ak + 1 : b * p + 1;
      begin_run(l, p, b);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk); start = 1'b0; abort = (k == ak);
        ev = model(k, l, p, b, ak); ov = observe();
        total++;
        if (ov !== ev) begin
          bad++;
          $display("FAIL random r=%0d l=%0d p=%0d b=%0d ak=%0d k=%0d got=%h exp=%h",
                   r, l, p, b, ak, k, ov, ev);
        end
      end
      abort = 1'b0;
      ev = model(n, l, p, b, ak);
      last_cnt = int'(ev[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_start_abort_idle();
    test_ignored_mid_run();
    test_continuous_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
